// File: rtl/muldiv_pkg.sv
// Shared op encodings and FSM state type for the multiply/divide unit.
// Signed operation support is enabled by defining MULDIV_SIGNED_EN.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling for muldiv_unit: operand magnitudes in, result negation out.
// Built only when MULDIV_SIGNED_EN is defined; otherwise a pass-through.
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic        signed_op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  output logic        a_neg,
  output logic        b_neg,
  input  logic        is_div,
  input  logic        neg_a,
  input  logic        neg_b,
  input  logic [63:0] raw,
  output logic [63:0] fixed
);

`ifdef MULDIV_SIGNED_EN
  always_comb begin
    a_neg = signed_op & a_in[31];
    b_neg = signed_op & b_in[31];
    a_mag = a_neg ? neg32(a_in) : a_in;
    b_mag = b_neg ? neg32(b_in) : b_in;
    fixed = raw;
    // quotient sign is the xor of operand signs; remainder follows the dividend
    if (is_div) begin
      if (neg_a ^ neg_b) fixed[31:0] = neg32(raw[31:0]);
      else               fixed[31:0] = raw[31:0];
      if (neg_a) fixed[63:32] = neg32(raw[63:32]);
      else       fixed[63:32] = raw[63:32];
    end else begin
      if (neg_a ^ neg_b) fixed = neg64(raw);
      else               fixed = raw;
    end
  end
`else
  logic unused_sign_s;
  assign unused_sign_s = ^{signed_op, is_div, neg_a, neg_b};
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = a_in;
  assign b_mag = b_in;
  assign fixed = raw;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider with HI/LO results.
// Define MULDIV_SIGNED_EN to make op 00/10 signed; otherwise all ops are unsigned.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_by_zero
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        flag_q, flag_d;

  logic [31:0] a_mag_s, b_mag_s;
  logic        a_neg_s, b_neg_s;
  logic [63:0] fixed_s;
  logic [32:0] sum_s;
  logic [63:0] mul_step_s;
  logic [32:0] rem_sh_s;
  logic [33:0] diff_s;
  logic [63:0] div_step_s;

  muldiv_signfix u_signfix (
    .signed_op (~op[0]),
    .a_in      (opA),
    .b_in      (opB),
    .a_mag     (a_mag_s),
    .b_mag     (b_mag_s),
    .a_neg     (a_neg_s),
    .b_neg     (b_neg_s),
    .is_div    (is_div_q),
    .neg_a     (neg_a_q),
    .neg_b     (neg_b_q),
    .raw       (acc_q),
    .fixed     (fixed_s)
  );

  // acc holds {upper, lower}: product/remainder above, multiplier/quotient below
  always_comb begin
    sum_s      = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    mul_step_s = acc_q[0] ? {sum_s, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    rem_sh_s   = {acc_q[63:32], acc_q[31]};
    diff_s     = {1'b0, rem_sh_s} - {2'b00, opnd_q};
    div_step_s = diff_s[33] ? {rem_sh_s[31:0], acc_q[30:0], 1'b0}
                            : {diff_s[31:0], acc_q[30:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    flag_d   = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          neg_a_d  = a_neg_s;
          neg_b_d  = b_neg_s;
          opnd_d   = b_mag_s;
          cnt_d    = 5'd0;
          flag_d   = 1'b0;
          dbz_d    = op[1] & (opB == 32'd0);
          if (!op[1]) begin
            acc_d   = {32'd0, a_mag_s};
            state_d = ST_MUL;
          end else if (opB != 32'd0) begin
            acc_d   = {32'd0, a_mag_s};
            state_d = ST_DIV;
          end else begin
            // divide by zero skips iteration; keep the raw dividend for hi
            acc_d   = {32'd0, opA};
            state_d = ST_FIX;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d = mul_step_s;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
        else                state_d = ST_MUL;
      end
      ST_DIV: begin
        acc_d = div_step_s;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
        else                state_d = ST_DIV;
      end
      ST_FIX: begin
        if (dbz_q) begin
          hi_d   = acc_q[31:0];
          lo_d   = 32'hFFFF_FFFF;
          flag_d = 1'b1;
        end else begin
          {hi_d, lo_d} = fixed_s;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      flag_q   <= flag_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = flag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expected values depend on MULDIV_SIGNED_EN.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .opA         (opA),
    .opB         (opB),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op, scramble the inputs after acceptance, wait for done and check results.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    int lat;
    @(negedge clk);
    op = o; opA = a; opB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; opA = ~a; opB = b ^ 32'h5A5A_0001;
    lat = 1;
    check({tag, "_flagclr"}, {63'd0, div_by_zero}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, {63'd0, (exp_lat > 2)});
    while (!done && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; start = 1'b0; op = 2'b00; opA = 32'd0; opB = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);

`ifdef MULDIV_SIGNED_EN
    run_op("mult_neg", OP_MULT, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_nn", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 34, 32'h0000_0000, 32'h0000_001E, 1'b0);
`else
    run_op("mult_neg", OP_MULT, 32'd7, 32'hFFFF_FFFD, 34, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_nn", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 34, 32'hFFFF_FFF5, 32'h0000_001E, 1'b0);
`endif
    // done pulse lasts one cycle only
    @(posedge clk); #1;
    check("done_pulse", {63'd0, done}, 64'd0);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
`else
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
`endif
    run_op("divu_b2b", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("div_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 2, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
`ifdef MULDIV_SIGNED_EN
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
`else
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'h0000_0000, 1'b0);
`endif

    // start pulsed while busy must be ignored
    @(negedge clk);
    op = OP_MULTU; opA = 32'd3; opB = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    op = OP_DIVU; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    while (!done && lat < 80) begin @(posedge clk); #1; lat++; end
    check("busy_ign_lat", 64'(lat), 64'd34);
    check("busy_ign_hi", {32'd0, hi}, 64'd0);
    check("busy_ign_lo", {32'd0, lo}, 64'd15);
    repeat (3) begin @(posedge clk); #1; end
    check("busy_ign_idle", {62'd0, busy, done}, 64'd0);

    // reset at cycle 10 of a mult aborts with no done
    @(negedge clk);
    op = OP_MULT; opA = 32'd7; opB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_nodone", 64'(seen), 64'd0);
    run_op("post_rst", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have port: opA  input  32  multiplicand or dividend.
REQ-007 SHALL have port: opB  input  32  multiplier or divisor.
REQ-008 SHALL have port: busy  output  1  high in MUL and DIV states.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: hi  output  32  HI register; product[63:32] or remainder.
REQ-011 SHALL have port: lo  output  32  LO register; product[31:0] or quotient.
REQ-012 SHALL have port: div_by_zero  output  1  sticky flag for the last op; cleared on next accepted start.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, FIX.
- IDLE: start=1 with op[1]=0 goes to MUL; with op[1]=1 and opB!=0 goes to DIV; with op[1]=1 and opB==0 goes to FIX.
- MUL and DIV go to FIX after the last step.
- FIX always returns to IDLE.
REQ-014 SHALL latch op, opA and opB on the accepting edge; later input changes have no effect.
REQ-015 SHALL do one shift-add multiply step per cycle in MUL and one restoring-divide step per cycle in DIV, 32 steps each, on operand magnitudes.
REQ-016 SHALL, in FIX, apply the sign correction and write hi/lo, then assert done for exactly that one cycle.
REQ-017 SHALL give a latency of 34 cycles from the accepting edge to done for mult/div (32 steps + FIX + accept), and 2 cycles for divide-by-zero.
REQ-018 SHALL ignore start while busy=1 or in FIX; the request is not queued.
REQ-019 SHALL hold hi and lo unchanged except in the FIX cycle.
REQ-020 SHALL, for mult/multu, set {hi,lo} to the full 64-bit product (signed or unsigned).
REQ-021 SHALL, for div/divu, set lo to the quotient truncated toward zero and hi to the remainder; the remainder takes the sign of the dividend.
REQ-022 SHALL, on divide by zero, set lo=32'hFFFFFFFF, hi=opA and div_by_zero=1.
REQ-023 SHALL, for signed 32'h80000000 / 32'hFFFFFFFF, set lo=32'h80000000 and hi=0 with no flag.
REQ-024 SHALL accept start=1 in the cycle after done (back-to-back operations).

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set state=IDLE, hi=0, lo=0, busy=0, done=0 and div_by_zero=0.
REQ-026 SHALL abort an in-progress operation on reset with no done pulse; rst has priority over start in the same cycle.

Configuration
REQ-027 SHALL support the macro MULDIV_SIGNED_EN.
- Defined: op 00 and 10 are signed; op 01 and 11 are unsigned.
- Undefined: op[0] is ignored, all operations are unsigned, and the sign-fix logic is not built; REQ-023 does not apply.

Structure
REQ-028 SHALL take the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state typedef from the shared package muldiv_pkg.
REQ-029 SHALL put sign handling (absolute value in, negate out) in one combinational sub-module, muldiv_signfix; the FSM and the iteration datapath stay in muldiv_unit.

Verification
REQ-030 SHALL cover: mult opA=7, opB=32'hFFFFFFFD -> done at +34, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-031 SHALL cover: multu opA=opB=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-032 SHALL cover: div opA=32'hFFFFFFF9, opB=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; then divu 100/7 back-to-back -> lo=14, hi=2.
REQ-033 SHALL cover: divu opA=5, opB=0 -> done at +2, lo=32'hFFFFFFFF, hi=5, div_by_zero=1; the next start clears the flag.
REQ-034 SHALL cover: start pulsed while busy -> ignored and the result is unchanged; rst at cycle 10 of a mult -> no done, hi=lo=0, IDLE.
